fsm_synapse_array: RTL and testbench

Bank of NSYN independent synapse FSMs sharing one unit clock and one gamma reset pulse. Each channel stores a WRES-bit weight and turns its input spike into a unary output train, using either the ramp-no-leak (RNL) or the step-no-leak (SNL) response. Each channel applies saturating STDP updates of configurable step size at gamma. The bank adds a direct weight-write port and a per-cycle count of active synapse outputs. It sits between the input spike encoders and the neuron body-potential accumulator of a column.

---
 rtl/fsm_synapse_array.sv | 160 ++++++++++++++++
 tb/tb_fsm_synapse_array.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_synapse_array.sv
// fsm_synapse_array
// Bank of NSYN synapse channels. Each channel holds a WRES-bit weight and
// turns one input spike per gamma cycle into a unary output train, using
// either the ramp-no-leak (RNL) or the step-no-leak (SNL) response.
// At gamma (grst), saturating STDP updates are applied and every channel is
// re-armed. A direct weight-write port and a per-cycle population count of
// active outputs are also provided.
module fsm_synapse_array #(
    parameter int NSYN   = 8,
    parameter int WRES   = 3,
    parameter int STEP   = 1,
    parameter int W_INIT = 0,
    parameter int AW     = (NSYN > 1) ? $clog2(NSYN) : 1,
    parameter int CW     = $clog2(NSYN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   grst,
    input  logic                   mode,
    input  logic [NSYN-1:0]        input_spike,
    input  logic [NSYN-1:0]        inc,
    input  logic [NSYN-1:0]        dec,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WRES-1:0]        wr_data,
    output logic [NSYN-1:0]        syn_out,
    output logic [CW-1:0]          syn_count,
    output logic [NSYN*WRES-1:0]   w_out
);

    localparam logic [WRES-1:0] WMAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Response select for the current gamma cycle.
    logic mode_q;

    // Saturating STDP increment: clamps at WMAX.
    function automatic logic [WRES-1:0] sat_inc(input logic [WRES-1:0] v);
        logic [WRES:0] s;
        s = {1'b0, v} + (WRES+1)'(STEP);
        return (s > {1'b0, WMAX}) ? WMAX : s[WRES-1:0];
    endfunction

    // Saturating STDP decrement: clamps at zero.
    function automatic logic [WRES-1:0] sat_dec(input logic [WRES-1:0] v);
        return (v < WRES'(STEP)) ? '0 : v - WRES'(STEP);
    endfunction

    // Latch the response mode once per gamma cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (grst) begin
            mode_q <= mode;
        end
    end

    for (genvar i = 0; i < NSYN; i++) begin : g_ch
        state_t          st;
        logic [WRES-1:0] w;
        logic [WRES-1:0] cnt;
        logic            wr_hit;
        logic            stdp_req;
        logic            start_count;
        logic            out_raw;

        assign wr_hit   = wr_en && (32'(wr_addr) == i);
        assign stdp_req = inc[i] || dec[i];

        // RNL needs at least one more counted cycle; SNL follows the spike
        // for any non-zero weight.
        assign start_count = mode_q ? (w != '0) : (w > WRES'(1));

        // Channel state, weight and remaining-count register.
        always_ff @(posedge clk) begin
            if (rst) begin
                w   <= WRES'(W_INIT);
                st  <= IDLE;
                cnt <= '0;
            end else if (grst) begin
                // A write to a channel with a pending STDP request loses.
                if (inc[i]) begin
                    w <= sat_inc(w);
                end else if (dec[i]) begin
                    w <= sat_dec(w);
                end else if (wr_hit) begin
                    w <= wr_data;
                end
                st  <= IDLE;
                cnt <= '0;
            end else begin
                // Writes never touch cnt, so an in-flight response keeps
                // the weight it started with.
                if (wr_hit) begin
                    w <= wr_data;
                end
                case (st)
                    IDLE: begin
                        if (input_spike[i]) begin
                            if (start_count) begin
                                st  <= COUNT;
                                cnt <= w - WRES'(1);
                            end else begin
                                st <= HOLD;
                            end
                        end
                    end
                    COUNT: begin
                        if (!input_spike[i]) begin
                            st <= HOLD;
                        end else if (!mode_q) begin
                            if (cnt == WRES'(1)) begin
                                st <= HOLD;
                            end else begin
                                cnt <= cnt - WRES'(1);
                            end
                        end
                    end
                    HOLD: begin
                        st <= HOLD;
                    end
                    default: begin
                        st <= HOLD;
                    end
                endcase
            end
        end

        // Zero-latency output decode from the channel state.
        always_comb begin
            out_raw = 1'b0;
            case (st)
                IDLE:    out_raw = input_spike[i] && (w != '0);
                COUNT:   out_raw = input_spike[i];
                default: out_raw = 1'b0;
            endcase
        end

        // Reset and gamma cycles suppress readout.
        assign syn_out[i] = out_raw && !rst && !grst;
        assign w_out[i*WRES +: WRES] = w;

        logic unused_stdp;
        assign unused_stdp = stdp_req;
    end

    // Population count of active synapse outputs in the same cycle.
    always_comb begin
        syn_count = '0;
        for (int k = 0; k < NSYN; k++) begin
            syn_count = syn_count + CW'(syn_out[k]);
        end
    end

endmodule

// File: tb/tb_fsm_synapse_array.sv
// Testbench for fsm_synapse_array: directed scenarios plus randomized
// traffic, all outputs compared every cycle against a behavioural model.
module tb_fsm_synapse_array;

    localparam int NSYN   = 8;
    localparam int WRES   = 3;
    localparam int STEP   = 2;
    localparam int W_INIT = 5;
    localparam int AW     = 3;
    localparam int CW     = 4;
    localparam int WMAXI  = 7;

    logic                 clk = 1'b0;
    logic                 rst, grst, mode, wr_en;
    logic [NSYN-1:0]      input_spike, inc, dec;
    logic [AW-1:0]        wr_addr;
    logic [WRES-1:0]      wr_data;
    logic [NSYN-1:0]      syn_out;
    logic [CW-1:0]        syn_count;
    logic [NSYN*WRES-1:0] w_out;

    always #5 clk = ~clk;

    fsm_synapse_array #(
        .NSYN(NSYN), .WRES(WRES), .STEP(STEP), .W_INIT(W_INIT), .AW(AW), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .grst(grst), .mode(mode),
        .input_spike(input_spike), .inc(inc), .dec(dec),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .syn_out(syn_out), .syn_count(syn_count), .w_out(w_out)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: weights, per-gamma spike bookkeeping.
    int mw[NSYN];
    bit started[NSYN];
    bit alive[NSYN];
    int wst[NSYN];
    int ocnt[NSYN];
    bit mode_m;
    int hi[NSYN];
    int c8;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs: high while the spike run that opened this gamma is
    // unbroken, the start weight is non-zero, and (RNL) fewer than w cycles
    // have been emitted.
    function automatic logic [NSYN-1:0] exp_out();
        logic [NSYN-1:0] e;
        bit a;
        int ws, oc;
        e = '0;
        for (int i = 0; i < NSYN; i++) begin
            if (started[i]) begin
                a = alive[i]; ws = wst[i]; oc = ocnt[i];
            end else begin
                a = 1'b1; ws = mw[i]; oc = 0;
            end
            e[i] = !rst && !grst && a && input_spike[i] && (ws != 0) && (mode_m || oc < ws);
        end
        return e;
    endfunction

    function automatic logic [NSYN*WRES-1:0] exp_w();
        logic [NSYN*WRES-1:0] v;
        for (int i = 0; i < NSYN; i++) v[i*WRES +: WRES] = WRES'(mw[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSYN; i++) begin
            mw[i] = W_INIT; started[i] = 0; alive[i] = 0; wst[i] = 0; ocnt[i] = 0;
        end
        mode_m = 0;
    endtask

    // Check this cycle, take the clock edge, advance the model.
    task automatic step();
        logic [NSYN-1:0] e;
        #2;
        e = exp_out();
        chk("syn_out", 32'(syn_out), 32'(e));
        chk("syn_count", 32'(syn_count), $countones(e));
        chk("w_out", 32'(w_out), 32'(exp_w()));
        for (int i = 0; i < NSYN; i++) hi[i] += int'(syn_out[i]);
        if (syn_count == CW'(NSYN)) c8++;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (grst) begin
            for (int i = 0; i < NSYN; i++) begin
                if (inc[i]) mw[i] = (mw[i] + STEP > WMAXI) ? WMAXI : mw[i] + STEP;
                else if (dec[i]) mw[i] = (mw[i] - STEP < 0) ? 0 : mw[i] - STEP;
                else if (wr_en && int'(wr_addr) == i) mw[i] = int'(wr_data);
                started[i] = 0;
            end
            mode_m = mode;
        end else begin
            for (int i = 0; i < NSYN; i++) begin
                if (!started[i]) begin
                    if (input_spike[i]) begin
                        started[i] = 1; alive[i] = 1; wst[i] = mw[i]; ocnt[i] = int'(e[i]);
                    end
                end else if (!input_spike[i]) begin
                    alive[i] = 0;
                end else begin
                    ocnt[i] += int'(e[i]);
                end
                if (wr_en && int'(wr_addr) == i) mw[i] = int'(wr_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic clr();
        rst = 0; grst = 0; wr_en = 0; inc = '0; dec = '0; input_spike = '0;
        wr_addr = '0; wr_data = '0;
    endtask

    task automatic wr(input int ch, input int d);
        wr_en = 1; wr_addr = AW'(ch); wr_data = WRES'(d);
        step(); clr();
    endtask

    task automatic gamma(input bit m);
        grst = 1; mode = m;
        step(); clr();
    endtask

    task automatic zero_hi();
        for (int i = 0; i < NSYN; i++) hi[i] = 0;
        c8 = 0;
    endtask

    task automatic spike_run(input logic [NSYN-1:0] mask, input int len);
        zero_hi();
        for (int k = 0; k < len; k++) begin
            input_spike = mask; step();
        end
        input_spike = '0; step(); step();
    endtask

    function automatic int wf(input int ch);
        logic [NSYN*WRES-1:0] v;
        v = w_out;
        return int'(v[ch*WRES +: WRES]);
    endfunction

    initial begin
        clr(); mode = 0; rst = 1;
        model_reset(); zero_hi();
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset state pinned to literals.
        chk("rst_w_out", 32'(w_out), 32'h00B6DB6D);
        chk("rst_syn_out", 32'(syn_out), 32'h0);
        chk("rst_syn_count", 32'(syn_count), 32'h0);
        step(); clr();

        // RNL readout, w=5, 7-cycle spike.
        wr(2, 5); gamma(0);
        spike_run(8'b0000_0100, 7);
        chk("rnl_len", hi[2], 5);
        chk("rnl_w_kept", wf(2), 5);

        // SNL full width, SNL zero weight.
        wr(3, 2); wr(4, 0); gamma(1);
        spike_run(8'b0001_1000, 7);
        chk("snl_len", hi[3], 7);
        chk("snl_w0", hi[4], 0);

        // RNL truncation by a short spike.
        wr(5, 6); gamma(0);
        spike_run(8'b0010_0000, 3);
        chk("rnl_trunc", hi[5], 3);

        // STDP saturation; write to ch0 on the same grst is dropped.
        wr(0, 6); wr(1, 1); wr(2, 3);
        inc = 8'b0000_0101; dec = 8'b0000_0110;
        wr_en = 1; wr_addr = 3'd0; wr_data = 3'd2;
        gamma(0);
        chk("stdp_inc_sat", wf(0), 7);
        chk("stdp_dec_sat", wf(1), 0);
        chk("stdp_inc_prio", wf(2), 5);
        // Write to a channel without an STDP request executes on grst.
        wr_en = 1; wr_addr = 3'd6; wr_data = 3'd4; inc = 8'b0000_0001;
        gamma(0);
        chk("grst_wr_other", wf(6), 4);

        // Write during a response keeps the in-flight length.
        wr(1, 4); gamma(0); zero_hi();
        input_spike = 8'b0000_0010; step();
        wr_en = 1; wr_addr = 3'd1; wr_data = 3'd1; step(); wr_en = 0;
        repeat (4) step();
        input_spike = '0; step();
        chk("wr_inflight_len", hi[1], 4);
        gamma(0);
        chk("wr_inflight_w", wf(1), 1);

        // Population count and re-arm.
        for (int i = 0; i < NSYN; i++) wr(i, 3);
        gamma(0);
        spike_run('1, 7);
        chk("pop8_cycles", c8, 3);
        spike_run('1, 3);
        chk("second_spike", hi[0] + hi[7], 0);
        gamma(0);
        spike_run('1, 2);
        chk("rearm", hi[0], 2);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            clr();
            if ($urandom_range(0, 2) == 0) input_spike = NSYN'($urandom);
            else input_spike = input_spike;
            rst = ($urandom_range(0, 199) == 0);
            grst = ($urandom_range(0, 11) == 0);
            if (grst) begin
                mode = 1'($urandom);
                inc = NSYN'($urandom) & NSYN'($urandom);
                dec = NSYN'($urandom) & NSYN'($urandom);
            end else begin
                inc = NSYN'($urandom); dec = NSYN'($urandom);
            end
            wr_en = ($urandom_range(0, 5) == 0);
            wr_addr = AW'($urandom); wr_data = WRES'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
